// File: rtl/fft_pkg.sv
// Shared IFFT datapath definitions: word formats, complex word type and the
// saturation helper used when narrowing full-precision products.
package fft_pkg;

  localparam int NBITS_DEFAULT = 16;
  localparam int FRAC_D        = 8;
  localparam int FRAC_W        = 14;

  typedef struct packed {
    logic signed [NBITS_DEFAULT-1:0] re;
    logic signed [NBITS_DEFAULT-1:0] im;
  } cplx_t;

  // Clamp a wide signed value into the signed range of an nbits-wide word.
  function automatic logic signed [63:0] sat_nbits(input logic signed [63:0] x,
                                                    input int nbits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nbits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cplx_mult_q14.sv
// Complex multiply by a 2.14 twiddle: registered partial products, then
// combine, truncating shift by the twiddle fraction and saturation.
module cplx_mult_q14
  import fft_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic signed [NBITS-1:0] pr_i,
  input  logic signed [NBITS-1:0] pi_i,
  input  logic signed [NBITS-1:0] wr_i,
  input  logic signed [NBITS-1:0] wi_i,
  output logic signed [NBITS-1:0] re_o,
  output logic signed [NBITS-1:0] im_o
);

  localparam int WP = 2 * NBITS;
  localparam int WF = 2 * NBITS + 1;

  logic signed [WP-1:0]    prwr_q, piwi_q, prwi_q, piwr_q;
  logic signed [WF-1:0]    reFull_d, imFull_d;
  logic signed [NBITS-1:0] re_q, im_q, re_d, im_d;

  always_ff @(posedge clk) begin
    if (en_i) begin
      prwr_q <= WP'(pr_i) * WP'(wr_i);
      piwi_q <= WP'(pi_i) * WP'(wi_i);
      prwi_q <= WP'(pr_i) * WP'(wi_i);
      piwr_q <= WP'(pi_i) * WP'(wr_i);
    end
  end

  // One extra bit keeps the sum/difference of two full products exact.
  always_comb begin
    reFull_d = WF'(prwr_q) - WF'(piwi_q);
    imFull_d = WF'(prwi_q) + WF'(piwr_q);
    re_d     = NBITS'(sat_nbits(64'(reFull_d >>> FRAC_W), NBITS));
    im_d     = NBITS'(sat_nbits(64'(imFull_d >>> FRAC_W), NBITS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en_i) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/ibutterfly4_dif.sv
// Radix-4 DIF inverse butterfly: sum, scale by 1/4, then twiddle outputs 1..3.
// Four-stage pipeline with a single global advance enable for backpressure.
module ibutterfly4_dif
  import fft_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [NBITS-1:0] Ar,
  input  logic signed [NBITS-1:0] Ai,
  input  logic signed [NBITS-1:0] Br,
  input  logic signed [NBITS-1:0] Bi,
  input  logic signed [NBITS-1:0] Cr,
  input  logic signed [NBITS-1:0] Ci,
  input  logic signed [NBITS-1:0] Dr,
  input  logic signed [NBITS-1:0] Di,
  input  logic signed [NBITS-1:0] W1r,
  input  logic signed [NBITS-1:0] W1i,
  input  logic signed [NBITS-1:0] W2r,
  input  logic signed [NBITS-1:0] W2i,
  input  logic signed [NBITS-1:0] W3r,
  input  logic signed [NBITS-1:0] W3i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [NBITS-1:0] X0r_F,
  output logic signed [NBITS-1:0] X0i_F,
  output logic signed [NBITS-1:0] X1r_F,
  output logic signed [NBITS-1:0] X1i_F,
  output logic signed [NBITS-1:0] X2r_F,
  output logic signed [NBITS-1:0] X2i_F,
  output logic signed [NBITS-1:0] X3r_F,
  output logic signed [NBITS-1:0] X3i_F
);

  localparam int SW = NBITS + 2;

  function automatic logic signed [SW-1:0] sx(input logic signed [NBITS-1:0] v);
    return SW'(v);
  endfunction

  function automatic logic signed [NBITS-1:0] quarter(input logic signed [SW-1:0] v);
    return NBITS'(v >>> 2);
  endfunction

  logic en;
  logic v1_q, v2_q, v3_q, outValid_q;

  logic signed [NBITS-1:0] s1r_q [4];
  logic signed [NBITS-1:0] s1i_q [4];
  logic signed [NBITS-1:0] s1wr_q [3];
  logic signed [NBITS-1:0] s1wi_q [3];
  logic signed [NBITS-1:0] s2r_q [4];
  logic signed [NBITS-1:0] s2i_q [4];
  logic signed [NBITS-1:0] s2wr_q [3];
  logic signed [NBITS-1:0] s2wi_q [3];
  logic signed [SW-1:0]    sumR_d [4];
  logic signed [SW-1:0]    sumI_d [4];
  logic signed [NBITS-1:0] x0r3_q, x0i3_q, x0r_q, x0i_q;
  logic signed [NBITS-1:0] mr [1:3];
  logic signed [NBITS-1:0] mi [1:3];

  assign en       = !outValid_q || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      outValid_q <= 1'b0;
    end else if (en) begin
      v1_q       <= in_valid;
      v2_q       <= v1_q;
      v3_q       <= v2_q;
      outValid_q <= v3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1r_q[0]  <= Ar;
      s1i_q[0]  <= Ai;
      s1r_q[1]  <= Br;
      s1i_q[1]  <= Bi;
      s1r_q[2]  <= Cr;
      s1i_q[2]  <= Ci;
      s1r_q[3]  <= Dr;
      s1i_q[3]  <= Di;
      s1wr_q[0] <= W1r;
      s1wi_q[0] <= W1i;
      s1wr_q[1] <= W2r;
      s1wi_q[1] <= W2i;
      s1wr_q[2] <= W3r;
      s1wi_q[2] <= W3i;
    end
  end

  // Index 0..3 holds A..D; +/-j rotations swap real/imaginary parts.
  always_comb begin
    sumR_d[0] = sx(s1r_q[0]) + sx(s1r_q[1]) + sx(s1r_q[2]) + sx(s1r_q[3]);
    sumI_d[0] = sx(s1i_q[0]) + sx(s1i_q[1]) + sx(s1i_q[2]) + sx(s1i_q[3]);
    sumR_d[1] = sx(s1r_q[0]) - sx(s1i_q[1]) - sx(s1r_q[2]) + sx(s1i_q[3]);
    sumI_d[1] = sx(s1i_q[0]) + sx(s1r_q[1]) - sx(s1i_q[2]) - sx(s1r_q[3]);
    sumR_d[2] = sx(s1r_q[0]) - sx(s1r_q[1]) + sx(s1r_q[2]) - sx(s1r_q[3]);
    sumI_d[2] = sx(s1i_q[0]) - sx(s1i_q[1]) + sx(s1i_q[2]) - sx(s1i_q[3]);
    sumR_d[3] = sx(s1r_q[0]) + sx(s1i_q[1]) - sx(s1r_q[2]) - sx(s1i_q[3]);
    sumI_d[3] = sx(s1i_q[0]) - sx(s1r_q[1]) - sx(s1i_q[2]) + sx(s1r_q[3]);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        s2r_q[k] <= quarter(sumR_d[k]);
        s2i_q[k] <= quarter(sumI_d[k]);
      end
      for (int k = 0; k < 3; k++) begin
        s2wr_q[k] <= s1wr_q[k];
        s2wi_q[k] <= s1wi_q[k];
      end
      x0r3_q <= s2r_q[0];
      x0i3_q <= s2i_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0r_q <= '0;
      x0i_q <= '0;
    end else if (en) begin
      x0r_q <= x0r3_q;
      x0i_q <= x0i3_q;
    end
  end

  for (genvar k = 1; k < 4; k++) begin : gMult
    cplx_mult_q14 #(.NBITS(NBITS)) uMult (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .pr_i (s2r_q[k]),
      .pi_i (s2i_q[k]),
      .wr_i (s2wr_q[k-1]),
      .wi_i (s2wi_q[k-1]),
      .re_o (mr[k]),
      .im_o (mi[k])
    );
  end

  assign out_valid = outValid_q;
  assign X0r_F     = x0r_q;
  assign X0i_F     = x0i_q;
  assign X1r_F     = mr[1];
  assign X1i_F     = mi[1];
  assign X2r_F     = mr[2];
  assign X2i_F     = mi[2];
  assign X3r_F     = mr[3];
  assign X3i_F     = mi[3];

endmodule

// File: tb/tb_ibutterfly4_dif.sv
// Directed and streamed checks of the radix-4 inverse butterfly against a
// behavioural model, with expected sets queued at acceptance.
module tb_ibutterfly4_dif;

  typedef struct {
    int ar, ai, br, bi, cr, ci, dr, di;
    int wr[3];
    int wi[3];
  } setIn_t;

  typedef struct {
    logic [127:0] exp;
    int           acc;
    int           id;
  } sbEntry_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [15:0] Ar, Ai, Br, Bi, Cr, Ci, Dr, Di;
  logic [15:0] W1r, W1i, W2r, W2i, W3r, W3i;
  logic [15:0] X0r_F, X0i_F, X1r_F, X1i_F, X2r_F, X2i_F, X3r_F, X3i_F;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nextId = 0;
  int lastLat = -1;
  bit accepted = 1'b0;
  bit prevStall = 1'b0;
  logic [127:0] prevObs = '0;
  setIn_t curSet;
  sbEntry_t sb[$];

  always #5 clk = ~clk;

  ibutterfly4_dif dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi), .Cr(Cr), .Ci(Ci), .Dr(Dr), .Di(Di),
    .W1r(W1r), .W1i(W1i), .W2r(W2r), .W2i(W2i), .W3r(W3r), .W3i(W3i),
    .out_valid(out_valid), .out_ready(out_ready),
    .X0r_F(X0r_F), .X0i_F(X0i_F), .X1r_F(X1r_F), .X1i_F(X1i_F),
    .X2r_F(X2r_F), .X2i_F(X2i_F), .X3r_F(X3r_F), .X3i_F(X3i_F)
  );

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Reference: X0=(A+B+C+D)/4, X1=W1(A+jB-C-jD)/4, X2=W2(A-B+C-D)/4, X3=W3(A-jB-C+jD)/4
  function automatic logic [127:0] model(input setIn_t s);
    longint sr[4];
    longint si[4];
    longint re, im;
    logic [127:0] res;
    sr[0] = s.ar + s.br + s.cr + s.dr;  si[0] = s.ai + s.bi + s.ci + s.di;
    sr[1] = s.ar - s.bi - s.cr + s.di;  si[1] = s.ai + s.br - s.ci - s.dr;
    sr[2] = s.ar - s.br + s.cr - s.dr;  si[2] = s.ai - s.bi + s.ci - s.di;
    sr[3] = s.ar + s.bi - s.cr - s.di;  si[3] = s.ai - s.br - s.ci + s.dr;
    for (int k = 0; k < 4; k++) begin
      sr[k] = sr[k] >>> 2;
      si[k] = si[k] >>> 2;
    end
    res[127:112] = sr[0][15:0];
    res[111:96]  = si[0][15:0];
    for (int k = 1; k < 4; k++) begin
      re = (sr[k] * s.wr[k-1] - si[k] * s.wi[k-1]) >>> 14;
      im = (sr[k] * s.wi[k-1] + si[k] * s.wr[k-1]) >>> 14;
      res[127-32*k -: 16] = sat16(re);
      res[111-32*k -: 16] = sat16(im);
    end
    return res;
  endfunction

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  function automatic setIn_t zeroSet();
    setIn_t s;
    s.ar = 0; s.ai = 0; s.br = 0; s.bi = 0;
    s.cr = 0; s.ci = 0; s.dr = 0; s.di = 0;
    for (int k = 0; k < 3; k++) begin
      s.wr[k] = 16384;
      s.wi[k] = 0;
    end
    return s;
  endfunction

  function automatic setIn_t randSet();
    setIn_t s;
    s.ar = rnd16(); s.ai = rnd16(); s.br = rnd16(); s.bi = rnd16();
    s.cr = rnd16(); s.ci = rnd16(); s.dr = rnd16(); s.di = rnd16();
    for (int k = 0; k < 3; k++) begin
      s.wr[k] = rnd16();
      s.wi[k] = rnd16();
    end
    return s;
  endfunction

  function automatic logic [127:0] curOut();
    return {X0r_F, X0i_F, X1r_F, X1i_F, X2r_F, X2i_F, X3r_F, X3i_F};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input setIn_t s);
    curSet = s;
    Ar = 16'(s.ar); Ai = 16'(s.ai); Br = 16'(s.br); Bi = 16'(s.bi);
    Cr = 16'(s.cr); Ci = 16'(s.ci); Dr = 16'(s.dr); Di = 16'(s.di);
    W1r = 16'(s.wr[0]); W1i = 16'(s.wi[0]);
    W2r = 16'(s.wr[1]); W2i = 16'(s.wi[1]);
    W3r = 16'(s.wr[2]); W3i = 16'(s.wi[2]);
  endtask

  // One cycle: sample just after the falling edge, score, then wait for the next one.
  task automatic tick();
    logic [127:0] obs;
    sbEntry_t e;
    #1;
    obs = curOut();
    if (prevStall) begin
      checkOutput("stall hold data", obs, prevObs);
      checkOutput("stall hold valid", 128'(out_valid), 128'd1);
    end
    if (out_valid && !out_ready && !rst)
      checkOutput("stall in_ready", 128'(in_ready), 128'd0);
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected output", 128'(out_valid), 128'd0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("set %0d", e.id), obs, e.exp);
        lastLat = cyc - e.acc;
      end
    end
    accepted = in_valid && in_ready && !rst;
    if (accepted) begin
      e.exp = model(curSet);
      e.acc = cyc;
      e.id  = nextId;
      nextId++;
      sb.push_back(e);
    end
    prevStall = out_valid && !out_ready && !rst;
    prevObs   = obs;
    cyc++;
    @(negedge clk);
  endtask

  task automatic sendOne(input setIn_t s);
    int n;
    n = 0;
    applyStimulus(s);
    in_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 20);
    in_valid = 1'b0;
    checkOutput("accept", 128'(accepted), 128'd1);
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    setIn_t s;
    setIn_t streamSets[8];
    int idx;
    int k;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    applyStimulus(zeroSet());
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset data", curOut(), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("in_ready after reset", 128'(in_ready), 128'd1);
    @(negedge clk);

    s = zeroSet();
    s.ar = 16'sh0100;
    sendOne(s);
    drain(20);
    checkOutput("impulse latency", 128'(lastLat), 128'd4);

    s = zeroSet();
    s.br = 16'sh0100;
    sendOne(s);
    s.wr[0] = 0;
    s.wi[0] = 16'sh4000;
    sendOne(s);
    s = zeroSet();
    s.ar = 16'sh7FFF;  s.ai = 16'sh7FFF;
    s.br = 16'sh7FFF;  s.bi = -32767;
    s.cr = -32767;     s.ci = -32767;
    s.dr = -32767;     s.di = 16'sh7FFF;
    s.wr[0] = 16'sh2D41;
    s.wi[0] = 16'shD2BF;
    sendOne(s);
    s = randSet();
    s.wr[1] = 16'shC000;
    s.wi[1] = 0;
    s.wr[2] = 16'shC000;
    s.wi[2] = 16'sh4000;
    sendOne(s);
    s = zeroSet();
    s.ar = -32768; s.br = -32768; s.cr = -32768; s.dr = -32768;
    s.wr[0] = 16'shC000;
    sendOne(s);
    drain(20);

    for (int i = 0; i < 8; i++) streamSets[i] = randSet();
    idx = 0;
    k = 0;
    while (idx < 8 && k < 100) begin
      applyStimulus(streamSets[idx]);
      in_valid = 1'b1;
      out_ready = !(k >= 5 && k < 10);
      tick();
      if (accepted) idx++;
      k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream accepted", 128'(idx), 128'd8);
    drain(40);

    for (int i = 0; i < 3; i++) sendOne(randSet());
    rst = 1'b1;
    tick();
    #1;
    checkOutput("midstream reset out_valid", 128'(out_valid), 128'd0);
    checkOutput("midstream reset data", curOut(), 128'd0);
    checkOutput("midstream reset in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    sb.delete();
    prevStall = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput("no stale set", 128'(out_valid), 128'd0);
      tick();
    end

    sendOne(randSet());
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
